// File: rtl/sw_mux_pkg.sv
// Shared types and helpers for the switch-output multiplexer arbiter.
// Imported by the arbiter top and reusable by other switch-side logic.
package sw_mux_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int NUM_SW_INST_DEF = 5;
   localparam int MAX_INST        = 32;

   function automatic logic [MAX_INST-1:0] onehot(input logic [7:0] idx);
      return {{(MAX_INST-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request after index ptr wins.
// Purely combinational; ptr is the most recent winner.
module rr_priority_pick #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any_req,
   output logic [IDX_W-1:0] winner
);

   logic found;
   int   idx;

   assign any_req = |req;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int off = 1; off <= N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/sw_mux_arbiter.sv
// Round-robin burst arbiter driving the switch-output multiplexer select.
// Grant is held until last, request withdrawal, or the beat cap.
module sw_mux_arbiter
   import sw_mux_pkg::*;
#(
   parameter int NUM_SW_INST = NUM_SW_INST_DEF,
   parameter int MAX_BURST   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SW_INST-1:0] req,
   input  logic [NUM_SW_INST-1:0] last,
   input  logic                   out_ready,
   output logic [NUM_SW_INST-1:0] sel,
   output logic [NUM_SW_INST-1:0] gnt,
   output logic                   out_valid,
   output logic                   out_last,
   output logic                   busy
);

   localparam int IDX_W = $clog2(NUM_SW_INST);
   localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CAP =
      (MAX_BURST == 0) ? '1 : CNT_W'(MAX_BURST - 1);

   state_e                 state, state_d;
   logic [IDX_W-1:0]       owner;
   logic [IDX_W-1:0]       ptr;
   logic [CNT_W-1:0]       beat_cnt;
   logic [IDX_W-1:0]       winner;
   logic                   any_req;
   logic [NUM_SW_INST-1:0] win_oh;
   logic                   in_burst;
   logic                   req_own;
   logic                   cap_hit;
   logic                   xfer;
   logic                   release_c;

   rr_priority_pick #(
      .N     (NUM_SW_INST),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .any_req (any_req),
      .winner  (winner)
   );

   assign win_oh    = NUM_SW_INST'(onehot(8'(winner)));
   assign in_burst  = (state == ST_BURST);
   assign req_own   = req[owner];
   assign cap_hit   = (MAX_BURST != 0) && (beat_cnt == CAP);
   assign xfer      = in_burst & req_own & out_ready;
   assign release_c = in_burst & ((xfer & (last[owner] | cap_hit)) | ~req_own);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE:  if (any_req)   state_d = ST_BURST;
         ST_BURST: if (release_c) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = in_burst & req_own;
      out_last  = in_burst & (last[owner] | cap_hit);
      gnt       = xfer ? sel : '0;
      busy      = in_burst;
   end

   // Counter saturates so an unlimited burst can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= '0;
         owner    <= '0;
         beat_cnt <= '0;
         ptr      <= IDX_W'(NUM_SW_INST - 1);
      end else if (!in_burst) begin
         if (any_req) begin
            sel      <= win_oh;
            owner    <= winner;
            beat_cnt <= '0;
         end
      end else if (release_c) begin
         sel      <= '0;
         ptr      <= owner;
         beat_cnt <= '0;
      end else if (xfer && beat_cnt != '1) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sw_mux_arbiter.sv
// Directed vector bench for sw_mux_arbiter with a 4-beat burst cap.
// Each row drives one cycle's inputs and lists that cycle's outputs.
module tb_sw_mux_arbiter;

   localparam int N  = 5;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] last = '0;
   logic         out_ready = 1'b0;
   logic [N-1:0] sel;
   logic [N-1:0] gnt;
   logic         out_valid;
   logic         out_last;
   logic         busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] last;
      logic         rdy;
      logic [N-1:0] sel;
      logic [N-1:0] gnt;
      logic         v;
      logic         l;
      logic         b;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   sw_mux_arbiter #(
      .NUM_SW_INST (N),
      .MAX_BURST   (MB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .out_ready (out_ready),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(string name, logic [N-1:0] got, logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [N-1:0] s, logic [N-1:0] g,
                          logic v, logic l, logic b);
      chk({tag, ".sel"}, sel, s);
      chk({tag, ".gnt"}, gnt, g);
      chk({tag, ".valid"}, N'(out_valid), N'(v));
      chk({tag, ".last"}, N'(out_last), N'(l));
      chk({tag, ".busy"}, N'(busy), N'(b));
   endtask

   function automatic void add(logic [N-1:0] r, logic [N-1:0] lt, logic rd,
                               logic [N-1:0] s, logic [N-1:0] g,
                               logic v, logic l, logic b);
      vec_t x;
      x.req = r; x.last = lt; x.rdy = rd;
      x.sel = s; x.gnt = g; x.v = v; x.l = l; x.b = b;
      vecs.push_back(x);
   endfunction

   initial begin
      // single requester, last on third beat
      add(5'b00001, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b00001, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, 1);
      add(5'b00001, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, 1);
      add(5'b00001, 5'b00001, 1, 5'b00001, 5'b00001, 1, 1, 1);
      add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      // round robin 1,2,4,1,2 with single-beat bursts
      add(5'b10110, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 5'b00010, 5'b00010, 1, 1, 1);
      add(5'b10110, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 5'b00100, 5'b00100, 1, 1, 1);
      add(5'b10110, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 5'b10000, 5'b10000, 1, 1, 1);
      add(5'b10110, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 5'b00010, 5'b00010, 1, 1, 1);
      add(5'b10110, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 5'b00100, 5'b00100, 1, 1, 1);
      add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      // beat cap on instance 3, re-grant, then withdrawal
      add(5'b01000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 0, 1);
      add(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 0, 1);
      add(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 0, 1);
      add(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 1, 1);
      add(5'b01000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 0, 1);
      add(5'b00000, 5'b00000, 1, 5'b01000, 5'b00000, 0, 0, 1);
      add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      // owner 2 with ready toggling; cap fires after 2 more beats
      add(5'b00100, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b00100, 5'b00000, 1, 5'b00100, 5'b00100, 1, 0, 1);
      add(5'b00100, 5'b00000, 0, 5'b00100, 5'b00000, 1, 0, 1);
      add(5'b00100, 5'b00000, 0, 5'b00100, 5'b00000, 1, 0, 1);
      add(5'b00100, 5'b00000, 1, 5'b00100, 5'b00100, 1, 0, 1);
      add(5'b00100, 5'b00000, 0, 5'b00100, 5'b00000, 1, 0, 1);
      add(5'b00100, 5'b00000, 1, 5'b00100, 5'b00100, 1, 0, 1);
      add(5'b00100, 5'b00000, 1, 5'b00100, 5'b00100, 1, 1, 1);
      add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      // owner 0 withdraws, instance 1 wins next
      add(5'b00011, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b00011, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, 1);
      add(5'b00010, 5'b00000, 1, 5'b00001, 5'b00000, 0, 0, 1);
      add(5'b00010, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
      add(5'b00010, 5'b00010, 1, 5'b00010, 5'b00010, 1, 1, 1);
      add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);

      req = '1;
      out_ready = 1'b1;
      #3;
      chk_all("reset", 5'b00000, 5'b00000, 0, 0, 0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         req       = vecs[i].req;
         last      = vecs[i].last;
         out_ready = vecs[i].rdy;
         #1;
         chk_all($sformatf("row%0d", i), vecs[i].sel, vecs[i].gnt,
                 vecs[i].v, vecs[i].l, vecs[i].b);
      end

      // asynchronous reset in the middle of a burst
      @(negedge clk);
      req = '1; last = '0; out_ready = 1'b1;
      #1;
      chk_all("ar_idle", 5'b00000, 5'b00000, 0, 0, 0);
      @(negedge clk);
      #1;
      chk_all("ar_burst", 5'b00100, 5'b00100, 1, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("ar_abort", 5'b00000, 5'b00000, 0, 0, 0);
      @(negedge clk);
      #1;
      chk_all("ar_held", 5'b00000, 5'b00000, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_all("ar_first", 5'b00001, 5'b00001, 1, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_mux_arbiter.md
Name: sw_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the switch-output multiplexer.
- Takes per-instance burst requests from NUM_SW_INST switch instances and drives the multiplexer's one-hot `sel` with the winner.
- Pops words from the granted instance under a valid/ready handshake with the downstream consumer.
- Grant is held for a whole burst: until `last`, until the request drops, or until MAX_BURST beats.

Parameters:
- NUM_SW_INST, 5, number of switch instances / request lines (>=2)
- MAX_BURST, 16, max beats per grant before forced release; 0 = unlimited
- CNT_W, $clog2(MAX_BURST+1) (min 1), beat counter width (derived, not overridden)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_SW_INST  req[i]=1: instance i has a word available
- last  input  NUM_SW_INST  last[i]=1: instance i's current word ends its burst
- out_ready  input  1  downstream accepts a word this cycle
- sel  output  NUM_SW_INST  one-hot select to multiplexer; all-zero when idle (registered)
- gnt  output  NUM_SW_INST  one-hot pop strobe: word of instance i transferred this cycle (combinational)
- out_valid  output  1  selected instance presents a valid word
- out_last  output  1  transferred/presented word is last of burst
- busy  output  1  state==BURST

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, sel=0, owner=0, beat_cnt=0, ptr=NUM_SW_INST-1 (instance 0 wins first).
  - gnt=0, out_valid=0, out_last=0, busy=0.
  - Reset mid-burst aborts immediately; no words are popped while rst_n=0.
- State IDLE:
  - sel=0, out_valid=0.
  - If |req: winner = first set req[k] scanning k = ptr+1, ptr+2, ... modulo NUM_SW_INST.
  - Next edge: state<=BURST, sel<=onehot(winner), owner<=winner, beat_cnt<=0.
  - Latency: req rising -> sel valid exactly 1 cycle later.
- State BURST:
  - out_valid = req[owner].
  - out_last = last[owner] | (MAX_BURST!=0 && beat_cnt==MAX_BURST-1).
  - gnt[owner] = out_valid & out_ready; all other gnt bits are 0.
  - On each transfer: beat_cnt<=beat_cnt+1.
  - Release condition, evaluated each cycle:
    - (a) transfer with last[owner]=1, or
    - (b) transfer with beat_cnt==MAX_BURST-1 (MAX_BURST!=0), or
    - (c) req[owner]=0 (owner withdrew; no transfer).
  - On release: state<=IDLE, sel<=0, ptr<=owner, beat_cnt<=0.
- Re-arbitration bubble: exactly one IDLE cycle between consecutive grants. Fixed and deterministic, so the downstream sees sel=0 for one cycle.
- out_ready=0 in BURST: hold sel, owner and beat_cnt; no gnt; no release unless (c).
- req changes of non-owners during BURST are ignored until the next IDLE.
- last[i] is ignored when i!=owner or when there is no transfer.
- Forced release (b): out_last=1 on the capped beat. The instance keeps its remaining data and re-requests; fairness comes from ptr.
- Only one request in the system: the same instance may win again after the bubble.
- beat_cnt never wraps. It is bounded by MAX_BURST; with MAX_BURST=0 it saturates at all-ones.
- Invariants:
  - sel is zero or one-hot.
  - gnt is a subset of sel.
  - busy == (sel!=0).

Decomposition:
- Shared package sw_mux_pkg:
  - state enum (ST_IDLE, ST_BURST)
  - NUM_SW_INST default
  - helper function for one-hot encode
- Sub-module rr_priority_pick:
  - combinational rotate-priority picker
  - inputs req[NUM_SW_INST], ptr index; outputs any_req and winner index
  - reusable by other switch-side arbiters

Test Plan:
- Reset then req=5'b00001, last[0] on 3rd beat, out_ready=1 -> sel=00001 one cycle after req; gnt[0] pulses 3 cycles; out_last on beat 3; sel=0 next cycle; busy falls.
- req=5'b10110 held, every burst 1 beat with last -> grant order 1,2,4,1,2 with one sel=0 bubble between grants.
- MAX_BURST=4, req[3]=1 held, last never set -> exactly 4 gnt[3] pulses, out_last on beat 4, bubble, then re-grant to 3 (only requester).
- Owner 2 granted, out_ready toggles 1,0,0,1 -> gnt[2] only in ready cycles; beat_cnt advances 2 total; sel stable throughout.
- Owner 0 mid-burst drops req[0] while req[1]=1 -> out_valid=0 that cycle; release with ptr=0; next grant is instance 1.
- Assert rst_n=0 asynchronously mid-burst (between clock edges) -> sel, gnt and out_valid go 0 immediately; after release with req=all-ones, instance 0 wins first.
